// File: rtl/draw_pkg.sv
// Shared constants and encodings for the board draw scheduler.
package draw_pkg;

    localparam int unsigned NUM_COLS    = 7;
    localparam int unsigned NUM_ROWS    = 6;
    localparam logic [2:0]  PREVIEW_ROW = 3'd0;
    localparam logic [2:0]  LAST_COL    = 3'(NUM_COLS - 1);
    localparam logic [2:0]  LAST_ROW    = 3'(NUM_ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        JOB_CLEAR,
        JOB_DROP,
        JOB_CURSOR
    } job_t;

endpackage

// File: rtl/draw_scheduler_sweep_counter.sv
// Raster counter for the clear sweep: column inner (0..last), row outer (1..last).
module sweep_counter
    import draw_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       advance,
    output logic [2:0] col,
    output logic [2:0] row,
    output logic       last
);

    assign last = (col == LAST_COL) && (row == LAST_ROW);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= 3'd1;
        end else if (start) begin
            col <= '0;
            row <= 3'd1;
        end else if (advance && !last) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates clear sweep > piece drop > cursor preview onto the single cell drawer.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 4095,
    parameter logic [2:0]  CURSOR_RST = 3'd3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear_req,
    input  logic       drop_req,
    input  logic [2:0] drop_col,
    input  logic [2:0] drop_row,
    input  logic       drop_player,
    input  logic       cursor_req,
    input  logic [2:0] cursor_col,
    input  logic       cursor_player,
    input  logic       draw_complete,
    output logic       draw_enable,
    output logic [2:0] draw_column,
    output logic [2:0] draw_row,
    output logic       draw_player,
    output logic       draw_reset_game,
    output logic       drop_ready,
    output logic       busy,
    output logic       drop_done,
    output logic       clear_done,
    output logic       req_err,
    output logic       draw_fault
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t         state, state_d;
    job_t           job;
    logic           clear_pend, drop_pend, cur_pend;
    logic           sweep_active, preview;
    logic [2:0]     drop_col_q, drop_row_q, cur_col_q, col_q, row_q;
    logic           drop_player_q, cur_player_q, player_q;
    logic [CW-1:0]  cnt;
    logic [2:0]     sw_col, sw_row;
    logic           sw_last, sw_advance;
    logic           ld_clear, ld_drop, ld_cursor, ld_preview, timeout;
    logic           drop_ok, drop_bad, cur_ok, cur_bad;

    sweep_counter u_sweep (
        .clk     (clk),
        .resetn  (resetn),
        .start   (ld_clear),
        .advance (sw_advance),
        .col     (sw_col),
        .row     (sw_row),
        .last    (sw_last)
    );

    assign draw_enable     = (state == S_ISSUE) || (state == S_WAIT);
    assign draw_column     = sweep_active ? sw_col : col_q;
    assign draw_row        = sweep_active ? sw_row : row_q;
    assign draw_player     = sweep_active ? 1'b0 : player_q;
    assign draw_reset_game = sweep_active;
    assign drop_ready      = !drop_pend && !(draw_enable && (job == JOB_DROP));
    assign busy            = (state != S_IDLE) || clear_pend || drop_pend || cur_pend;

    // A clear in the same cycle wins over a drop, which is then rejected.
    assign drop_ok  = drop_req && !clear_req && drop_ready && (drop_col <= LAST_COL)
                      && (drop_row != 3'd0) && (drop_row <= LAST_ROW);
    assign drop_bad = drop_req && !drop_ok;
    assign cur_ok   = cursor_req && (cursor_col <= LAST_COL);
    assign cur_bad  = cursor_req && !cur_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d    = state;
        ld_clear   = 1'b0;
        ld_drop    = 1'b0;
        ld_cursor  = 1'b0;
        ld_preview = 1'b0;
        sw_advance = 1'b0;
        timeout    = 1'b0;
        drop_done  = 1'b0;
        clear_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear_pend) begin
                    ld_clear = 1'b1;
                    state_d  = S_ISSUE;
                end else if (drop_pend) begin
                    ld_drop = 1'b1;
                    state_d = S_ISSUE;
                end else if (cur_pend) begin
                    ld_cursor = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (draw_complete) begin
                    state_d = S_RELEASE;
                end else if (cnt == CW'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                if (job == JOB_CLEAR) begin
                    // Sweep jobs chain straight back to ISSUE; a new clear restarts the raster.
                    if (clear_pend) begin
                        ld_clear = 1'b1;
                        state_d  = S_ISSUE;
                    end else if (!preview) begin
                        ld_preview = sw_last;
                        sw_advance = !sw_last;
                        state_d    = S_ISSUE;
                    end else begin
                        clear_done = 1'b1;
                    end
                end else if (job == JOB_DROP) begin
                    drop_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            job           <= JOB_CLEAR;
            clear_pend    <= 1'b0;
            drop_pend     <= 1'b0;
            cur_pend      <= 1'b0;
            sweep_active  <= 1'b0;
            preview       <= 1'b0;
            drop_col_q    <= '0;
            drop_row_q    <= '0;
            drop_player_q <= 1'b0;
            cur_col_q     <= CURSOR_RST;
            cur_player_q  <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            player_q      <= 1'b0;
            cnt           <= '0;
            req_err       <= 1'b0;
            draw_fault    <= 1'b0;
        end else begin
            req_err <= drop_bad || cur_bad;

            if (clear_req)     clear_pend <= 1'b1;
            else if (ld_clear) clear_pend <= 1'b0;

            if (clear_req)    drop_pend <= 1'b0;
            else if (drop_ok) drop_pend <= 1'b1;
            else if (ld_drop) drop_pend <= 1'b0;

            if (clear_req)      cur_pend <= 1'b0;
            else if (cur_ok)    cur_pend <= 1'b1;
            else if (ld_cursor) cur_pend <= 1'b0;

            if (drop_ok) begin
                drop_col_q    <= drop_col;
                drop_row_q    <= drop_row;
                drop_player_q <= drop_player;
            end
            if (cur_ok) begin
                cur_col_q    <= cursor_col;
                cur_player_q <= cursor_player;
            end

            if (ld_clear) begin
                job          <= JOB_CLEAR;
                sweep_active <= 1'b1;
                preview      <= 1'b0;
            end
            if (ld_preview || ld_cursor) begin
                sweep_active <= 1'b0;
                preview      <= ld_preview;
                col_q        <= cur_col_q;
                row_q        <= PREVIEW_ROW;
                player_q     <= cur_player_q;
            end
            if (ld_cursor) job <= JOB_CURSOR;
            if (ld_drop) begin
                job      <= JOB_DROP;
                col_q    <= drop_col_q;
                row_q    <= drop_row_q;
                player_q <= drop_player_q;
            end

            if (state == S_ISSUE)     cnt <= '0;
            else if (state == S_WAIT) cnt <= cnt + 1'b1;

            if (timeout) draw_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with a simple drawer responder and job logger.
module tb_draw_scheduler;

    logic       clk;
    logic       resetn;
    logic       clear_req, drop_req, cursor_req;
    logic [2:0] drop_col, drop_row, cursor_col;
    logic       drop_player, cursor_player;
    logic       draw_complete;
    logic       draw_enable, draw_player, draw_reset_game;
    logic [2:0] draw_column, draw_row;
    logic       drop_ready, busy, drop_done, clear_done, req_err, draw_fault;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] col;
        logic [2:0] row;
        logic       pl;
        logic       rg;
        int         gap;
    } job_rec_t;

    job_rec_t jobs[$];
    logic     en_prev = 1'b0;
    int       low_run = 0;
    int       clear_done_cnt = 0;
    logic     auto_complete = 1'b1;
    int       lat = 0;

    draw_scheduler dut (
        .clk             (clk),
        .resetn          (resetn),
        .clear_req       (clear_req),
        .drop_req        (drop_req),
        .drop_col        (drop_col),
        .drop_row        (drop_row),
        .drop_player     (drop_player),
        .cursor_req      (cursor_req),
        .cursor_col      (cursor_col),
        .cursor_player   (cursor_player),
        .draw_complete   (draw_complete),
        .draw_enable     (draw_enable),
        .draw_column     (draw_column),
        .draw_row        (draw_row),
        .draw_player     (draw_player),
        .draw_reset_game (draw_reset_game),
        .drop_ready      (drop_ready),
        .busy            (busy),
        .drop_done       (drop_done),
        .clear_done      (clear_done),
        .req_err         (req_err),
        .draw_fault      (draw_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drawer model: done rises a few cycles after enable, falls once enable drops.
    always @(posedge clk) begin
        if (!draw_enable) begin
            draw_complete <= 1'b0;
            lat           <= 0;
        end else if (lat >= 3) begin
            draw_complete <= auto_complete;
        end else begin
            lat <= lat + 1;
        end
    end

    always @(negedge clk) begin
        if (draw_enable && !en_prev)
            jobs.push_back('{draw_column, draw_row, draw_player, draw_reset_game, low_run});
        if (draw_enable) low_run = 0;
        else             low_run = low_run + 1;
        en_prev = draw_enable;
        if (clear_done) clear_done_cnt = clear_done_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int pack(input job_rec_t r);
        return int'({r.rg, r.pl, r.row, r.col});
    endfunction

    function automatic int exp_pack(input int rg, input int pl, input int row, input int col);
        return rg * 128 + pl * 64 + row * 8 + col;
    endfunction

    // sel: 0 drop_done, 1 clear_done, 2 draw_enable, 3 idle (busy low)
    task automatic wait_for(input int sel, input int limit, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((sel == 0 && drop_done) || (sel == 1 && clear_done) ||
                (sel == 2 && draw_enable) || (sel == 3 && !busy)) begin
                hit = 1'b1;
                break;
            end
        end
        check(tag, int'(hit), 1);
    endtask

    task automatic do_drop(input int col, input int row, input int pl);
        drop_col = 3'(col); drop_row = 3'(row); drop_player = pl[0];
        drop_req = 1'b1;
        @(posedge clk); #1 drop_req = 1'b0;
    endtask

    task automatic do_cursor(input int col, input int pl);
        cursor_col = 3'(col); cursor_player = pl[0];
        cursor_req = 1'b1;
        @(posedge clk); #1 cursor_req = 1'b0;
    endtask

    task automatic do_clear();
        clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; clear_req = 1'b0; drop_req = 1'b0; cursor_req = 1'b0;
        drop_col = '0; drop_row = '0; drop_player = 1'b0;
        cursor_col = '0; cursor_player = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_enable", int'(draw_enable), 0);
        check("rst_drop_ready", int'(drop_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_fault", int'(draw_fault), 0);
        check("rst_req_err", int'(req_err), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // single drop while idle
        jobs.delete();
        do_drop(2, 6, 1);
        @(negedge clk);
        check("drop_enable_early", int'(draw_enable), 0);
        @(negedge clk);
        check("drop_enable", int'(draw_enable), 1);
        check("drop_cell", int'({draw_player, draw_row, draw_column}), 64 + 6 * 8 + 2);
        check("drop_ready_busy", int'(drop_ready), 0);
        wait_for(0, 50, "drop_done_seen");
        check("drop_done_enable", int'(draw_enable), 0);
        check("drop_done_ready", int'(drop_ready), 1);
        @(negedge clk);
        check("drop_done_pulse", int'(drop_done), 0);
        check("drop_idle", int'(busy), 0);
        check("drop_jobs", jobs.size(), 1);

        // full clear after reset: 42 white cells then preview at (3, player 0)
        jobs.delete();
        do_clear();
        wait_for(1, 2000, "clear_done_seen");
        check("clear_jobs", jobs.size(), 43);
        if (jobs.size() >= 43) begin
            for (int i = 0; i < 42; i++) begin
                check("clear_cell", pack(jobs[i]), exp_pack(1, 0, i / 7 + 1, i % 7));
                if (i > 0) check("clear_gap", jobs[i].gap, 1);
            end
            check("clear_preview", pack(jobs[42]), exp_pack(0, 0, 0, 3));
            check("clear_preview_gap", jobs[42].gap, 1);
        end
        @(negedge clk);
        check("clear_idle", int'(busy), 0);

        // priority: drop beats cursor in the same cycle
        jobs.delete();
        cursor_col = 3'd5; cursor_player = 1'b1; cursor_req = 1'b1;
        do_drop(1, 1, 0);
        cursor_req = 1'b0;
        wait_for(3, 200, "prio_idle");
        check("prio_jobs", jobs.size(), 2);
        if (jobs.size() >= 2) begin
            check("prio_first", pack(jobs[0]), exp_pack(0, 0, 1, 1));
            check("prio_second", pack(jobs[1]), exp_pack(0, 1, 0, 5));
        end

        // cursor coalescing during a drop
        jobs.delete();
        do_drop(0, 2, 1);
        wait_for(2, 20, "coal_enable");
        do_cursor(1, 0);
        do_cursor(4, 0);
        do_cursor(6, 1);
        wait_for(3, 200, "coal_idle");
        check("coal_jobs", jobs.size(), 2);
        if (jobs.size() >= 2) check("coal_cursor", pack(jobs[1]), exp_pack(0, 1, 0, 6));

        // rejected requests
        jobs.delete();
        @(negedge clk);
        do_drop(1, 0, 0);
        @(negedge clk);
        check("err_row0", int'(req_err), 1);
        @(negedge clk);
        check("err_pulse", int'(req_err), 0);
        do_drop(7, 3, 0);
        @(negedge clk);
        check("err_col7", int'(req_err), 1);
        do_drop(4, 4, 0);
        @(negedge clk);
        do_drop(5, 5, 0);
        @(negedge clk);
        check("err_not_ready", int'(req_err), 1);
        wait_for(3, 200, "err_idle");
        check("err_jobs", jobs.size(), 1);
        if (jobs.size() >= 1) check("err_served", pack(jobs[0]), exp_pack(0, 0, 4, 4));
        do_cursor(7, 0);
        @(negedge clk);
        check("err_cursor7", int'(req_err), 1);
        check("err_cursor_nojob", int'(busy), 0);

        // cursor register must still be (6, player 1)
        jobs.delete();
        do_clear();
        wait_for(1, 2000, "clear2_done_seen");
        check("clear2_jobs", jobs.size(), 43);
        if (jobs.size() >= 43) check("clear2_preview", pack(jobs[42]), exp_pack(0, 1, 0, 6));

        // timeout: drawer never completes
        auto_complete = 1'b0;
        @(negedge clk);
        do_drop(3, 3, 0);
        wait_for(2, 20, "to_enable");
        repeat (4090) @(negedge clk);
        check("to_fault_early", int'(draw_fault), 0);
        repeat (10) @(negedge clk);
        check("to_fault", int'(draw_fault), 1);
        check("to_enable_low", int'(draw_enable), 0);
        check("to_idle", int'(busy), 0);
        check("to_ready", int'(drop_ready), 1);
        auto_complete = 1'b1;

        // reset in the middle of a sweep
        do_clear();
        repeat (60) @(negedge clk);
        wait_for(2, 20, "rst_mid_enable");
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_enable_low", int'(draw_enable), 0);
        check("rst_mid_fault", int'(draw_fault), 0);
        check("rst_mid_busy", int'(busy), 0);
        clear_done_cnt = 0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (500) @(negedge clk);
        check("rst_mid_no_clear_done", clear_done_cnt, 0);
        check("rst_mid_stays_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Sequences the board cell drawer: owns its column/row/enable/player/resetGame inputs and its drawComplete output.
- Arbitrates three requesters, in priority order clear > drop > cursor:
  - full-board clear sweep (game reset)
  - single piece drop into a board cell
  - cursor preview redraw on row 0
- Sits between the game FSM and the drawer. It is the only driver of the drawer's inputs.

Parameters:
- NUM_COLS, 7, board columns; valid column indices 0..NUM_COLS-1.
- NUM_ROWS, 6, board rows; valid board rows 1..NUM_ROWS; row 0 is the preview strip.
- TIMEOUT, 4095, maximum cycles to wait for draw_complete before aborting the job.
- CURSOR_RST, 3, cursor column after reset.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- clear_req  in  1  pulse: clear all board cells, then redraw the preview
- drop_req  in  1  pulse: draw one piece; accepted only while drop_ready=1
- drop_col  in  3  column of the piece, sampled with drop_req
- drop_row  in  3  row of the piece (1..NUM_ROWS), sampled with drop_req
- drop_player  in  1  player of the piece, sampled with drop_req
- cursor_req  in  1  pulse: redraw the preview strip
- cursor_col  in  3  preview column, sampled with cursor_req
- cursor_player  in  1  preview player, sampled with cursor_req
- draw_complete  in  1  drawer done flag
- draw_enable  out  1  drawer enable
- draw_column  out  3  drawer column
- draw_row  out  3  drawer row
- draw_player  out  1  drawer player
- draw_reset_game  out  1  high during the clear sweep, so cells are drawn white
- drop_ready  out  1  no drop is pending or in flight
- busy  out  1  not IDLE, or any request pending
- drop_done  out  1  one-cycle pulse when the drop draw finishes
- clear_done  out  1  one-cycle pulse when the sweep and preview finish
- req_err  out  1  one-cycle pulse when a request is rejected
- draw_fault  out  1  sticky; set on timeout, cleared only by resetn

Behaviour:
- Reset:
  - all outputs 0 except drop_ready=1
  - cursor register = (CURSOR_RST, player 0)
  - pending flags cleared; FSM in IDLE
- Request latching (every cycle, in any state):
  - clear_req sets clear_pend. It also discards a pending (not in-flight) drop and a pending cursor redraw.
  - drop_req with drop_ready=1 and a valid column and row latches the drop and sets drop_pend.
  - An invalid drop_req (column >= NUM_COLS, row 0 or row > NUM_ROWS) is dropped and pulses req_err.
  - A drop_req arriving while drop_ready=0 is also dropped and pulses req_err.
  - cursor_req with column < NUM_COLS overwrites the cursor register (last one wins) and sets cur_pend.
  - cursor_req with column >= NUM_COLS pulses req_err and changes nothing.
  - Same-cycle clear_req and drop_req: the clear wins and the drop is rejected (req_err).
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
- IDLE: pick the highest-priority pending job and load the draw_* outputs:
  - clear: start the sweep at row 1, column 0, draw_reset_game=1
  - drop: latched column/row/player
  - cursor: row 0, cursor register
  - Go to ISSUE the next cycle.
- ISSUE:
  - draw_enable=1; draw_* outputs held stable; the timeout counter is cleared.
  - Go to WAIT.
- WAIT:
  - draw_enable stays 1.
  - draw_complete=1 goes to RELEASE.
  - The counter reaching TIMEOUT sets draw_fault and goes to RELEASE (job treated as finished).
- RELEASE:
  - draw_enable=0 for exactly one cycle; this re-arms the drawer.
  - Then either advance the sweep or retire the job.
- Sweep order:
  - raster: column 0..NUM_COLS-1 inner, row 1..NUM_ROWS outer
  - after cell (NUM_COLS-1, NUM_ROWS): one row-0 preview draw with the cursor register and draw_reset_game=0
  - then pulse clear_done; total NUM_COLS*NUM_ROWS+1 draw jobs
- Job completion:
  - a drop pulses drop_done in RELEASE; drop_ready returns to 1 the same cycle
  - cur_pend is cleared when the cursor job is loaded; a cursor_req arriving during the job sets it again
- Preemption: none. A job in flight always completes. A clear_req during a drop draw starts the sweep after that drop finishes.
- A clear_req during a sweep restarts the sweep from row 1, column 0 at the next RELEASE.
- draw_* outputs change only in IDLE or RELEASE, never while draw_enable=1.
- resetn assertion mid-job: draw_enable drops immediately (asynchronous); all state returns to its reset values.

Decomposition:
- Package draw_pkg: state enum, NUM_COLS, NUM_ROWS, PREVIEW_ROW=0, CLEAR/DROP/CURSOR job codes.
- Sub-module sweep_counter: the column/row raster counter with start, advance and last outputs.

Test Plan:
- Drop, idle: drop_req col 2 row 6 player 1 -> draw_enable rises 2 cycles later with column 2, row 6, player 1; draw_complete -> one cycle with enable low, then drop_done pulse; drop_ready back to 1.
- Clear: clear_req -> 42 jobs with draw_reset_game=1 in raster order, then a row-0 job using the cursor register (3, player 0 after reset) -> clear_done; every job separated by one enable-low cycle.
- Priority: cursor_req col 5 and drop_req col 1 row 1 in the same cycle while idle -> drop served first, then the row-0 job with column 5.
- Cursor coalescing: during a drop draw, cursor_req cols 1, 4, 6 -> exactly one row-0 job, with column 6.
- Errors: drop_req with row 0, column 7, or while drop_ready=0 -> req_err pulse, no draw job; cursor_req col 7 -> req_err, cursor register unchanged.
- Timeout and reset: draw_complete held low -> draw_fault set after TIMEOUT cycles and the scheduler returns to IDLE; resetn low mid-sweep -> draw_enable=0 at once, clear_done never pulses, draw_fault cleared.
